// File: rtl/z3_pkg.sv
// Shared encodings and helpers for the Zorro III slave cycle engine.
package z3_pkg;

  localparam int Z3_STATE_W          = 3;
  localparam int Z3_TIMEOUT_DEFAULT  = 255;

  typedef logic [Z3_STATE_W-1:0] z3_state_t;

  localparam z3_state_t ST_IDLE  = 3'd0;
  localparam z3_state_t ST_START = 3'd1;
  localparam z3_state_t ST_DATA  = 3'd2;
  localparam z3_state_t ST_END   = 3'd3;
  localparam z3_state_t ST_MWAIT = 3'd4;
  localparam z3_state_t ST_ERR   = 3'd5;

  // Isolates the least significant set bit; callers narrow the result to their width.
  function automatic logic [31:0] lowest_one(input logic [31:0] v);
    return v & (~v + 32'd1);
  endfunction

endpackage

// File: rtl/z3_sync.sv
// Multi-flop synchroniser for asynchronous active-low bus strobes; resets to negated.
module z3_sync #(
  parameter int WIDTH  = 6,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  localparam int NSTG = (STAGES < 2) ? 2 : STAGES;

  logic [WIDTH-1:0] stage [NSTG];

  // NOTE: sequential state uses non-blocking assignments so every stage samples the pre-edge value.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NSTG; i++) stage[i] <= '1;
    end else begin
      stage[0] <= d;
      for (int i = 1; i < NSTG; i++) stage[i] <= stage[i-1];
    end
  end

  assign q = stage[NSTG-1];

endmodule

// File: rtl/z3_slave_ctrl.sv
// Zorro III slave cycle engine: target arbitration, burst handshake, DTACK timeout.
module z3_slave_ctrl
  import z3_pkg::*;
#(
  parameter int NUM_TGT        = 5,
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = Z3_TIMEOUT_DEFAULT,
  parameter int MULTI_EN       = 1,
  parameter int BEAT_W         = 8
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               FCS_n,
  input  logic [3:0]         DS_n,
  input  logic               MTCR_n,
  input  logic               READ,
  input  logic               DOE,
  input  logic               match,
  input  logic               validspace,
  input  logic [NUM_TGT-1:0] tgt_sel,
  input  logic [NUM_TGT-1:0] tgt_ack,
  output logic [NUM_TGT-1:0] tgt_start,
  output logic [NUM_TGT-1:0] cycle_tgt,
  output logic               DTACK,
  output logic               MTACK,
  output logic               BERR,
  output logic               busy,
  output logic [BEAT_W-1:0]  beat_cnt,
  output logic [7:0]         err_cnt
);

  localparam logic MULTI = (MULTI_EN != 0);

  logic [5:0] sync_q;
  logic       fcs, ds_any, mtcr;
  logic       req_data, own_ack, timed_out, enter_data;
  logic [31:0] timer;
  z3_state_t  state, state_nxt;

  z3_sync #(.WIDTH(6), .STAGES(SYNC_STAGES)) u_sync (
    .clk   (CLK),
    .reset (RESET),
    .d     ({MTCR_n, DS_n, FCS_n}),
    .q     (sync_q)
  );

  assign fcs       = ~sync_q[0];
  assign ds_any    = |(~sync_q[4:1]);
  assign mtcr      = ~sync_q[5];
  assign req_data  = READ || (ds_any && DOE);
  assign own_ack   = |(tgt_ack & cycle_tgt);
  assign timed_out = (TIMEOUT_CYCLES != 0) && (timer == 32'(TIMEOUT_CYCLES - 1));

  always_comb begin
    // NOTE: defaulting next state before the case keeps this purely combinational (no latch).
    state_nxt = state;
    case (state)
      ST_IDLE:  if (fcs && match && validspace && (|tgt_sel)) state_nxt = ST_START;
      ST_START: if (!fcs) state_nxt = ST_IDLE;
                else if (req_data) state_nxt = ST_DATA;
      ST_DATA:  if (!fcs) state_nxt = ST_IDLE;
                else if (own_ack) state_nxt = ST_END;
                else if (timed_out) state_nxt = ST_ERR;
      ST_END:   if (!fcs) state_nxt = ST_IDLE;
                else if (MULTI && !ds_any && !mtcr) state_nxt = ST_MWAIT;
      ST_MWAIT: if (!fcs || !MULTI) state_nxt = ST_IDLE;
                else if (mtcr && req_data) state_nxt = ST_DATA;
      ST_ERR:   if (!fcs) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  assign enter_data = (state_nxt == ST_DATA) && (state != ST_DATA);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state     <= ST_IDLE;
      cycle_tgt <= '0;
      tgt_start <= '0;
      beat_cnt  <= '0;
      err_cnt   <= '0;
      timer     <= '0;
    end else begin
      state     <= state_nxt;
      tgt_start <= enter_data ? cycle_tgt : '0;

      if (state_nxt == ST_IDLE)
        cycle_tgt <= '0;
      else if (state == ST_IDLE)
        cycle_tgt <= NUM_TGT'(lowest_one(32'(tgt_sel)));

      if (state_nxt == ST_IDLE)
        beat_cnt <= '0;
      else if (state == ST_DATA && state_nxt == ST_END)
        beat_cnt <= beat_cnt + BEAT_W'(1);

      if (state == ST_DATA && state_nxt == ST_ERR && err_cnt != 8'hFF)
        err_cnt <= err_cnt + 8'd1;

      if (enter_data)
        timer <= '0;
      else if (state == ST_DATA)
        timer <= timer + 32'd1;
    end
  end

  // Status outputs are decoded from the registered state, so they change on the entering edge.
  assign DTACK = (state == ST_END);
  assign BERR  = (state == ST_ERR);
  assign MTACK = MULTI && (state != ST_IDLE);
  assign busy  = (state != ST_IDLE);

endmodule

// File: tb/tb_z3_slave_ctrl.sv
// Directed bench: a burst-capable and a single-transfer instance share one stimulus stream.
module tb_z3_slave_ctrl;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic       FCS_n = 1'b1;
  logic [3:0] DS_n = 4'hF;
  logic       MTCR_n = 1'b1;
  logic       READ = 1'b0;
  logic       DOE = 1'b0;
  logic       match = 1'b0;
  logic       validspace = 1'b0;
  logic [4:0] tgt_sel = '0;
  logic [4:0] tgt_ack = '0;

  logic [4:0] tgt_start_m, cycle_tgt_m, tgt_start_s, cycle_tgt_s;
  logic       DTACK_m, MTACK_m, BERR_m, busy_m;
  logic       DTACK_s, MTACK_s, BERR_s, busy_s;
  logic [7:0] beat_cnt_m, err_cnt_m, beat_cnt_s, err_cnt_s;

  int n_vec = 0;
  int n_err = 0;
  int starts_m = 0;
  int starts_s = 0;
  int s0m, s0s;

  always #5 CLK = ~CLK;

  z3_slave_ctrl #(.NUM_TGT(5), .SYNC_STAGES(2), .TIMEOUT_CYCLES(16), .MULTI_EN(1), .BEAT_W(8)) u_m (
    .CLK(CLK), .RESET(RESET), .FCS_n(FCS_n), .DS_n(DS_n), .MTCR_n(MTCR_n), .READ(READ),
    .DOE(DOE), .match(match), .validspace(validspace), .tgt_sel(tgt_sel), .tgt_ack(tgt_ack),
    .tgt_start(tgt_start_m), .cycle_tgt(cycle_tgt_m), .DTACK(DTACK_m), .MTACK(MTACK_m),
    .BERR(BERR_m), .busy(busy_m), .beat_cnt(beat_cnt_m), .err_cnt(err_cnt_m)
  );

  z3_slave_ctrl #(.NUM_TGT(5), .SYNC_STAGES(2), .TIMEOUT_CYCLES(16), .MULTI_EN(0), .BEAT_W(8)) u_s (
    .CLK(CLK), .RESET(RESET), .FCS_n(FCS_n), .DS_n(DS_n), .MTCR_n(MTCR_n), .READ(READ),
    .DOE(DOE), .match(match), .validspace(validspace), .tgt_sel(tgt_sel), .tgt_ack(tgt_ack),
    .tgt_start(tgt_start_s), .cycle_tgt(cycle_tgt_s), .DTACK(DTACK_s), .MTACK(MTACK_s),
    .BERR(BERR_s), .busy(busy_s), .beat_cnt(beat_cnt_s), .err_cnt(err_cnt_s)
  );

  always @(negedge CLK) begin
    if (|tgt_start_m) starts_m <= starts_m + 1;
    if (|tgt_start_s) starts_s <= starts_s + 1;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  // Drops the bus cycle and waits out the synchroniser plus the return edge.
  task automatic release_bus();
    FCS_n = 1'b1; DS_n = 4'hF; MTCR_n = 1'b1; READ = 1'b0; DOE = 1'b0; tgt_ack = '0;
    tick(3);
  endtask

  // Starts a read with data strobes asserted; returns with the engine in START.
  task automatic open_read(input logic [4:0] sel);
    tgt_sel = sel; match = 1'b1; validspace = 1'b1; READ = 1'b1; DS_n = 4'h0; FCS_n = 1'b0;
    tick(3);
  endtask

  initial begin
    tick(2);
    RESET = 1'b0;
    tick(1);
    check("rst_busy",      32'(busy_m),      32'd0);
    check("rst_dtack",     32'(DTACK_m),     32'd0);
    check("rst_mtack",     32'(MTACK_m),     32'd0);
    check("rst_berr",      32'(BERR_m),      32'd0);
    check("rst_beat",      32'(beat_cnt_m),  32'd0);
    check("rst_err",       32'(err_cnt_m),   32'd0);
    check("rst_cycle_tgt", 32'(cycle_tgt_m), 32'd0);
    check("rst_tgt_start", 32'(tgt_start_m), 32'd0);

    // Read to target 2
    tgt_sel = 5'b00100; match = 1'b1; validspace = 1'b1; READ = 1'b1; DS_n = 4'h0; FCS_n = 1'b0;
    tick(2);
    check("rd_sync_latency_busy", 32'(busy_m), 32'd0);
    tick(1);
    check("rd_start_busy",    32'(busy_m),      32'd1);
    check("rd_start_mtack_m", 32'(MTACK_m),     32'd1);
    check("rd_start_mtack_s", 32'(MTACK_s),     32'd0);
    check("rd_cycle_tgt",     32'(cycle_tgt_m), 32'b00100);
    check("rd_no_early_pulse",32'(tgt_start_m), 32'd0);
    tick(1);
    check("rd_tgt_start",     32'(tgt_start_m), 32'b00100);
    tick(1);
    check("rd_tgt_start_once",32'(tgt_start_m), 32'd0);
    check("rd_dtack_wait",    32'(DTACK_m),     32'd0);
    tick(1);
    tgt_ack = 5'b00100;
    tick(1);
    check("rd_dtack",         32'(DTACK_m),     32'd1);
    check("rd_beat",          32'(beat_cnt_m),  32'd1);
    tgt_ack = '0;
    tick(4);
    check("rd_dtack_hold",    32'(DTACK_m),     32'd1);
    FCS_n = 1'b1; DS_n = 4'hF; READ = 1'b0;
    tick(2);
    check("rd_dtack_until_fcs", 32'(DTACK_m),   32'd1);
    tick(1);
    check("rd_end_dtack",     32'(DTACK_m),     32'd0);
    check("rd_end_busy",      32'(busy_m),      32'd0);
    check("rd_end_beat",      32'(beat_cnt_m),  32'd0);
    check("rd_end_cycle_tgt", 32'(cycle_tgt_m), 32'd0);
    check("rd_end_mtack",     32'(MTACK_m),     32'd0);

    // Write with two selects; DOE gates entry to DATA
    tgt_sel = 5'b01010; READ = 1'b0; DOE = 1'b0; DS_n = 4'b1100; FCS_n = 1'b0;
    tick(3);
    check("wr_cycle_tgt",     32'(cycle_tgt_m), 32'b00010);
    tick(3);
    check("wr_hold_start",    32'(tgt_start_m), 32'd0);
    check("wr_hold_busy",     32'(busy_m),      32'd1);
    DOE = 1'b1;
    tick(1);
    check("wr_tgt_start",     32'(tgt_start_m), 32'b00010);
    tgt_ack = 5'b01000;
    tick(2);
    check("wr_foreign_ack",   32'(DTACK_m),     32'd0);
    tgt_ack = 5'b00010;
    tick(1);
    check("wr_dtack",         32'(DTACK_m),     32'd1);
    check("wr_beat",          32'(beat_cnt_m),  32'd1);
    release_bus();

    // Single timeout
    open_read(5'b00001);
    tick(1);
    check("to_tgt_start",     32'(tgt_start_m), 32'b00001);
    tick(15);
    check("to_berr_early",    32'(BERR_m),      32'd0);
    tick(1);
    check("to_berr",          32'(BERR_m),      32'd1);
    check("to_dtack",         32'(DTACK_m),     32'd0);
    check("to_err_cnt",       32'(err_cnt_m),   32'd1);
    FCS_n = 1'b1; DS_n = 4'hF; READ = 1'b0;
    tick(2);
    check("to_berr_hold",     32'(BERR_m),      32'd1);
    tick(1);
    check("to_berr_clear",    32'(BERR_m),      32'd0);
    check("to_idle",          32'(busy_m),      32'd0);

    // Ack in the timeout cycle wins
    open_read(5'b00001);
    tick(1);
    tick(15);
    check("race_berr_pre",    32'(BERR_m),      32'd0);
    tgt_ack = 5'b00001;
    tick(1);
    check("race_dtack",       32'(DTACK_m),     32'd1);
    check("race_berr",        32'(BERR_m),      32'd0);
    check("race_err_cnt",     32'(err_cnt_m),   32'd1);
    release_bus();

    // FCS negated in DATA aborts without DTACK
    open_read(5'b00001);
    tick(1);
    check("abort_busy",       32'(busy_m),      32'd1);
    FCS_n = 1'b1; DS_n = 4'hF; READ = 1'b0;
    tick(2);
    check("abort_dtack",      32'(DTACK_m),     32'd0);
    tick(1);
    check("abort_idle",       32'(busy_m),      32'd0);
    check("abort_beat",       32'(beat_cnt_m),  32'd0);
    release_bus();

    // No target selected, then invalid space
    tgt_sel = 5'b00000; match = 1'b1; validspace = 1'b1; READ = 1'b1; DS_n = 4'h0; FCS_n = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick(1);
      check("nosel_busy",     32'(busy_m),      32'd0);
    end
    check("nosel_tgt_start",  32'(tgt_start_m), 32'd0);
    check("nosel_cycle_tgt",  32'(cycle_tgt_m), 32'd0);
    release_bus();
    tgt_sel = 5'b00100; validspace = 1'b0; READ = 1'b1; DS_n = 4'h0; FCS_n = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick(1);
      check("badspace_busy",  32'(busy_m),      32'd0);
    end
    check("badspace_mtack",   32'(MTACK_m),     32'd0);
    release_bus();
    validspace = 1'b1;

    // Four-beat burst
    s0m = starts_m; s0s = starts_s;
    tgt_sel = 5'b10000; match = 1'b1; READ = 1'b1; DS_n = 4'h0; MTCR_n = 1'b0; FCS_n = 1'b0;
    tick(3);
    check("bu_mtack_m",       32'(MTACK_m),     32'd1);
    check("bu_mtack_s",       32'(MTACK_s),     32'd0);
    tick(1);
    for (int b = 0; b < 4; b++) begin
      tgt_ack = 5'b10000;
      tick(1);
      tgt_ack = '0;
      check("bu_beat",        32'(beat_cnt_m),  32'(b + 1));
      check("bu_dtack",       32'(DTACK_m),     32'd1);
      if (b < 3) begin
        DS_n = 4'hF; MTCR_n = 1'b1;
        tick(3);
        check("bu_mwait_dtack", 32'(DTACK_m),   32'd0);
        check("bu_mwait_mtack", 32'(MTACK_m),   32'd1);
        check("bu_single_hold", 32'(DTACK_s),   32'd1);
        DS_n = 4'h0; MTCR_n = 1'b0;
        tick(3);
      end
    end
    check("bu_beats_m",       32'(beat_cnt_m),    32'd4);
    check("bu_beats_s",       32'(beat_cnt_s),    32'd1);
    check("bu_starts_m",      32'(starts_m - s0m), 32'd4);
    check("bu_starts_s",      32'(starts_s - s0s), 32'd1);
    check("bu_mtack_s_end",   32'(MTACK_s),       32'd0);
    release_bus();
    check("bu_beat_clear",    32'(beat_cnt_m),    32'd0);

    // Saturating timeout counter: 299 more timeouts, 300 in total
    for (int i = 0; i < 299; i++) begin
      open_read(5'b00001);
      tick(17);
      release_bus();
      if (i == 198) check("sat_err_200", 32'(err_cnt_m), 32'd200);
    end
    check("sat_err_m",        32'(err_cnt_m),   32'd255);
    check("sat_err_s",        32'(err_cnt_s),   32'd255);

    // Reset while in END
    open_read(5'b00100);
    tick(1);
    tgt_ack = 5'b00100;
    tick(1);
    check("rstend_dtack_pre", 32'(DTACK_m),     32'd1);
    RESET = 1'b1;
    tick(1);
    check("rstend_dtack",     32'(DTACK_m),     32'd0);
    check("rstend_busy",      32'(busy_m),      32'd0);
    check("rstend_err",       32'(err_cnt_m),   32'd0);
    check("rstend_beat",      32'(beat_cnt_m),  32'd0);
    check("rstend_mtack",     32'(MTACK_m),     32'd0);
    RESET = 1'b0;
    release_bus();
    check("rstend_idle",      32'(busy_m),      32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/z3_slave_ctrl.md
Name: z3_slave_ctrl

Overview:
- Parametrised Zorro III slave cycle engine that generalises the card's fixed four-state slave FSM.
- Supports NUM_TGT decoded targets, optional multiple-transfer (MTCR/MTACK) bursts, a per-beat DTACK timeout with BERR, and configurable synchroniser depth.
- Sits between the address latch/decoder and the target access blocks (ROM, SID, SCSI, INTREG); the top level drives the open-drain pins from its active-high outputs.

Parameters:
- NUM_TGT, 5: number of target channels; tgt_sel/tgt_ack/tgt_start/cycle_tgt width.
- SYNC_STAGES, 2: flops per synchroniser, minimum 2.
- TIMEOUT_CYCLES, 255: CLK cycles in DATA before BERR. 0 disables the timeout.
- MULTI_EN, 1: 1 enables multiple-transfer cycles. 0 never asserts MTACK and never enters MWAIT.
- BEAT_W, 8: width of beat_cnt.

Ports:
- CLK  in  1  system clock.
- RESET  in  1  synchronous, active-high reset.
- FCS_n  in  1  Zorro FCS, asynchronous, active low.
- DS_n  in  4  data strobes, asynchronous, active low.
- MTCR_n  in  1  multiple-transfer strobe, asynchronous, active low.
- READ  in  1  1 = read cycle.
- DOE  in  1  data output enable from the bus.
- match  in  1  latched address hit.
- validspace  in  1  FC[1]^FC[0].
- tgt_sel  in  NUM_TGT  decoder target selects; more than one bit may be set.
- tgt_ack  in  NUM_TGT  per-target completion, level.
- tgt_start  out  NUM_TGT  one-cycle start pulse per beat.
- cycle_tgt  out  NUM_TGT  one-hot owning target, held for the whole cycle.
- DTACK  out  1  data acknowledge, active high.
- MTACK  out  1  multiple-transfer acknowledge, active high.
- BERR  out  1  bus error, active high.
- busy  out  1  state != IDLE.
- beat_cnt  out  BEAT_W  completed beats in the current FCS cycle.
- err_cnt  out  8  saturating timeout counter.

Behaviour:
- Clock and reset: one clock (CLK). Reset is synchronous and active-high (RESET).
- Reset, any state: state=IDLE; all outputs 0; err_cnt=0; every synchroniser stage set to 1 (negated).
- Synchronisers: fcs, ds_any = OR of negated DS bits, and mtcr are taken after SYNC_STAGES flops. READ, DOE, match, validspace and tgt_sel are sampled raw.
- IDLE:
  - Go to START when fcs && match && validspace && |tgt_sel.
  - On that transition, cycle_tgt := lowest set bit of tgt_sel.
  - If tgt_sel==0, stay in IDLE and give no response.
- START:
  - MTACK = MULTI_EN.
  - !fcs -> IDLE.
  - READ || (ds_any && DOE) -> DATA.
- Entry to DATA (from START or MWAIT): tgt_start = cycle_tgt for exactly one cycle (the first DATA cycle); the timer is cleared.
- DATA:
  - !fcs -> IDLE (abort: no DTACK, beat not counted).
  - |(tgt_ack & cycle_tgt) -> END and beat_cnt += 1. beat_cnt wraps from 2^BEAT_W-1 to 0.
  - Otherwise, if TIMEOUT_CYCLES!=0 and the timer reaches TIMEOUT_CYCLES-1 -> ERR and err_cnt += 1, saturating at 255.
  - If an ack and the timeout occur in the same cycle, the ack wins.
  - Acks on non-owning targets are ignored.
- END:
  - DTACK=1 for every cycle in END (registered; it rises on the edge that enters END).
  - !fcs -> IDLE; DTACK falls on that same edge.
  - Else if MULTI_EN && !ds_any && !mtcr -> MWAIT; DTACK falls.
- MWAIT (only when MULTI_EN=1):
  - DTACK=0, MTACK=1.
  - !fcs -> IDLE.
  - mtcr && (READ || (ds_any && DOE)) -> DATA, with a new tgt_start pulse.
- ERR:
  - BERR=1 and DTACK=0 while in ERR.
  - !fcs -> IDLE; BERR falls on that edge.
- On return to IDLE: cycle_tgt, beat_cnt and MTACK clear on the same edge.
- Encoding: IDLE=0, START=1, DATA=2, END=3, MWAIT=4, ERR=5 (3-bit). Unused codes -> IDLE.
- FCS negated in any state returns to IDLE on the next edge. There is no latency beyond synchroniser depth + 1.

Decomposition:
- Package z3_pkg: state enum and encodings, Z3_STATE_W=3, default TIMEOUT_CYCLES, helper function lowest_one(NUM_TGT).
- Sub-module z3_sync: parametrised WIDTH/STAGES synchroniser, reset value all-ones. Instanced once for {MTCR_n, DS_n, FCS_n} (6 bits).

Test Plan:
- Read, tgt_sel=5'b00100, READ=1: after FCS_n low, tgt_start=00100 for 1 cycle. Tgt 2 acks 3 cycles later -> DTACK high until FCS_n high, then beat_cnt returns to 0.
- Write, tgt_sel=5'b01010: ds_any with DOE=0 holds START. DOE=1 -> DATA, cycle_tgt=00010 (lowest bit). An ack on bit 3 is ignored; an ack on bit 1 -> DTACK.
- Timeout, TIMEOUT_CYCLES=16, no ack: BERR rises 16 cycles after DATA entry and err_cnt=1. FCS_n high clears BERR. 300 timeouts -> err_cnt=255.
- Burst, MULTI_EN=1: 4 beats, each with DS/MTCR negated then reasserted. MTACK is high from START onward, 4 tgt_start pulses occur, beat_cnt=4 before FCS_n negates. With MULTI_EN=0 the same stimulus gives MTACK=0 and only 1 beat.
- Boundary: ack and timeout in the same cycle -> DTACK, not BERR. FCS_n negates in DATA -> IDLE with no DTACK. RESET pulsed in END -> DTACK=0 next edge, state IDLE, err_cnt=0.
- tgt_sel=0 with match=1, or validspace=0 -> busy stays 0 and no outputs change for the whole FCS cycle.
